// File: rtl/lsu_dmem_ctrl.sv
// Load/store initiator for a word-wide, byte-enabled data memory.
// Optional LSU_MISALIGN_SPLIT_EN: misaligned accesses run as two word cycles instead of erroring.
module lsu_dmem_ctrl #(
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    output logic [3:0]  we,
    input  logic [31:0] drdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC0 = 2'd1;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam logic [1:0] ACC1 = 2'd2;
`endif
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        load_q, load_d;
    logic        err_q, err_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [3:0]  mask0_q, mask0_d;
    logic [31:0] word0_q, word0_d;
    logic [31:0] daddr_q, daddr_d;
    logic [31:0] dwdata_q, dwdata_d;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic [3:0]  mask1_q, mask1_d;
    logic [31:0] word1_q, word1_d;
`endif

    logic [3:0]  bmask;
    logic [7:0]  mask_wide;
    logic        f3_ok;
    logic [1:0]  extra;
    logic [32:0] last_byte;
    logic        oob;
    logic        misalign;
    logic        req_err;
    logic [31:0] rep;
    logic [31:0] wrot;

    // Request decode: byte mask, range check and lane-aligned write data.
    always_comb begin
        case (req_funct3[1:0])
            2'b00:   bmask = 4'b0001;
            2'b01:   bmask = 4'b0011;
            default: bmask = 4'b1111;
        endcase
        mask_wide = {4'b0000, bmask} << req_addr[1:0];

        case (req_funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = req_load;
            default:                f3_ok = 1'b0;
        endcase

        case (req_funct3[1:0])
            2'b00:   extra = 2'd0;
            2'b01:   extra = 2'd1;
            default: extra = 2'd3;
        endcase
        last_byte = {1'b0, req_addr} + 33'(extra);
        oob       = last_byte >= 33'(MEM_BYTES);

`ifdef LSU_MISALIGN_SPLIT_EN
        misalign = 1'b0;
`else
        // Anything crossing a word, plus odd-offset halfwords inside a word.
        misalign = (|mask_wide[7:4]) || ((req_funct3[1:0] == 2'b01) && req_addr[0]);
`endif
        req_err = !f3_ok || misalign || oob;

        case (req_funct3[1:0])
            2'b00:   rep = {4{req_wdata[7:0]}};
            2'b01:   rep = {2{req_wdata[15:0]}};
            default: rep = req_wdata;
        endcase
        // Rotating the replicated data serves both cycles of a split access.
        case (req_addr[1:0])
            2'd0:    wrot = rep;
            2'd1:    wrot = {rep[23:0], rep[31:24]};
            2'd2:    wrot = {rep[15:0], rep[31:16]};
            default: wrot = {rep[7:0], rep[31:8]};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        load_d   = load_q;
        err_d    = err_q;
        f3_d     = f3_q;
        off_d    = off_q;
        mask0_d  = mask0_q;
        word0_d  = word0_q;
        daddr_d  = daddr_q;
        dwdata_d = dwdata_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        mask1_d  = mask1_q;
        word1_d  = word1_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    load_d  = req_load;
                    f3_d    = req_funct3;
                    off_d   = req_addr[1:0];
                    mask0_d = mask_wide[3:0];
`ifdef LSU_MISALIGN_SPLIT_EN
                    mask1_d = mask_wide[7:4];
`endif
                    err_d   = req_err;
                    if (req_err) begin
                        state_d = RESP;
                    end else begin
                        state_d  = ACC0;
                        daddr_d  = {req_addr[31:2], 2'b00};
                        dwdata_d = wrot;
                    end
                end
            end
            ACC0: begin
                if (load_q) begin
                    word0_d = drdata;
                end
                state_d = RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
                if (|mask1_q) begin
                    state_d = ACC1;
                    daddr_d = daddr_q + 32'd4;
                end
`endif
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ACC1: begin
                if (load_q) begin
                    word1_d = drdata;
                end
                state_d = RESP;
            end
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            load_q   <= 1'b0;
            err_q    <= 1'b0;
            f3_q     <= 3'b000;
            off_q    <= 2'd0;
            mask0_q  <= 4'b0000;
            word0_q  <= 32'd0;
            daddr_q  <= 32'd0;
            dwdata_q <= 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
            mask1_q  <= 4'b0000;
            word1_q  <= 32'd0;
`endif
        end else begin
            state_q  <= state_d;
            load_q   <= load_d;
            err_q    <= err_d;
            f3_q     <= f3_d;
            off_q    <= off_d;
            mask0_q  <= mask0_d;
            word0_q  <= word0_d;
            daddr_q  <= daddr_d;
            dwdata_q <= dwdata_d;
`ifdef LSU_MISALIGN_SPLIT_EN
            mask1_q  <= mask1_d;
            word1_q  <= word1_d;
`endif
        end
    end

    logic [63:0] pair;
    logic [31:0] shifted;
    logic [31:0] ext;

    always_comb begin
`ifdef LSU_MISALIGN_SPLIT_EN
        pair = {word1_q, word0_q};
`else
        pair = {32'd0, word0_q};
`endif
        shifted = 32'(pair >> {off_q, 3'b000});
        case (f3_q)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ext = {24'd0, shifted[7:0]};
            3'b101:  ext = {16'd0, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    // we is derived from state so an asynchronous reset drops it at once.
    always_comb begin
        we = 4'b0000;
        if (!load_q) begin
            case (state_q)
                ACC0:    we = mask0_q;
`ifdef LSU_MISALIGN_SPLIT_EN
                ACC1:    we = mask1_q;
`endif
                default: we = 4'b0000;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && load_q && !err_q) ? ext : 32'd0;
    assign daddr      = daddr_q;
    assign dwdata     = dwdata_q;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Randomized self-checking bench for lsu_dmem_ctrl against a byte-level memory model.
// Honors LSU_MISALIGN_SPLIT_EN to match the DUT build.
module tb_lsu_dmem_ctrl;

    localparam int unsigned MemBytes = 128;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SplitEn = 1'b1;
`else
    localparam bit SplitEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_load;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata, daddr, dwdata, drdata;
    logic [3:0]  we;

    lsu_dmem_ctrl #(.MEM_BYTES(MemBytes)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_load   (req_load),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .daddr      (daddr),
        .dwdata     (dwdata),
        .we         (we),
        .drdata     (drdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_resp;
        logic [3:0]  we;
        logic [31:0] daddr;
        logic [31:0] dw;
        logic [31:0] rdata;
        bit          err;
    } rec_t;

    rec_t        exp_q[$];
    logic [7:0]  simmem[MemBytes];
    logic [7:0]  refmem[MemBytes];
    bit          mem_init = 1'b1;
    bit          hold_chk = 1'b0;
    int          tests = 0;
    int          fails = 0;
    int          acc_n = 0;
    logic [31:0] last_rdata, last_daddr0, last_daddr1, last_dw0;
    logic [3:0]  last_we0, last_we1;
    logic        last_err;

    // Memory the DUT talks to: combinational read, byte-enabled write at posedge.
    always_comb begin
        drdata = 32'd0;
        for (int l = 0; l < 4; l++) begin
            if (longint'(daddr) + l < MemBytes) drdata[l*8 +: 8] = simmem[longint'(daddr) + l];
        end
    end

    always @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (mem_init) simmem[l] <= refmem[l];
        end
        if (mem_init) begin
            for (int i = 4; i < MemBytes; i++) simmem[i] <= refmem[i];
        end else begin
            for (int l = 0; l < 4; l++) begin
                if (we[l] && longint'(daddr) + l < MemBytes)
                    simmem[longint'(daddr) + l] <= dwdata[l*8 +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] m);
        logic [31:0] r;
        r = 32'd0;
        for (int l = 0; l < 4; l++) if (m[l]) r[l*8 +: 8] = 8'hFF;
        return r;
    endfunction

    // Per-cycle compare against the expected trace; an empty trace means idle.
    always @(posedge clk) begin
        #1;
        if (!reset && !hold_chk) begin
            if (exp_q.size() == 0) begin
                chk("idle_ready", {31'd0, req_ready}, 32'd1);
                chk("idle_resp_valid", {31'd0, resp_valid}, 32'd0);
                chk("idle_we", {28'd0, we}, 32'd0);
            end else begin
                rec_t r;
                r = exp_q.pop_front();
                if (r.is_resp) begin
                    chk("resp_valid", {31'd0, resp_valid}, 32'd1);
                    chk("resp_ready", {31'd0, req_ready}, 32'd0);
                    chk("resp_we", {28'd0, we}, 32'd0);
                    chk("resp_rdata", resp_rdata, r.rdata);
                    chk("resp_err", {31'd0, resp_err}, {31'd0, r.err});
                    last_rdata = resp_rdata;
                    last_err   = resp_err;
                    acc_n      = 0;
                end else begin
                    chk("acc_ready", {31'd0, req_ready}, 32'd0);
                    chk("acc_resp_valid", {31'd0, resp_valid}, 32'd0);
                    chk("acc_we", {28'd0, we}, {28'd0, r.we});
                    chk("acc_daddr", daddr, r.daddr);
                    chk("acc_dwdata", dwdata & lane_mask(r.we), r.dw & lane_mask(r.we));
                    if (acc_n == 0) begin
                        last_we0 = we; last_daddr0 = daddr; last_dw0 = dwdata;
                    end else begin
                        last_we1 = we; last_daddr1 = daddr;
                    end
                    acc_n++;
                end
            end
        end
    end

    // Reference: applies the access byte by byte to refmem and builds the expected trace.
    task automatic model(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] w);
        int unsigned size, off;
        longint unsigned la, b;
        bit legal, mis, oob, second;
        logic [3:0] we0, we1;
        logic [31:0] dw0, dw1, val, res;
        rec_t r;
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        la    = a;
        off   = a % 4;
        mis   = !SplitEn && ((size == 2 && off % 2 == 1) || (size == 4 && off != 0));
        oob   = la + size - 1 >= MemBytes;
        r = '{is_resp: 1'b1, we: 4'd0, daddr: 32'd0, dw: 32'd0, rdata: 32'd0, err: 1'b1};
        if (!legal || mis || oob) begin
            exp_q.push_back(r);
            return;
        end
        we0 = 0; we1 = 0; dw0 = 0; dw1 = 0; val = 0; second = 0;
        for (int unsigned i = 0; i < size; i++) begin
            b = la + i;
            if (b / 4 == la / 4) begin
                we0[b % 4] = 1'b1; dw0[(b % 4) * 8 +: 8] = w[i*8 +: 8];
            end else begin
                we1[b % 4] = 1'b1; dw1[(b % 4) * 8 +: 8] = w[i*8 +: 8]; second = 1;
            end
            if (ld) val[i*8 +: 8] = refmem[b];
            else    refmem[b] = w[i*8 +: 8];
        end
        exp_q.push_back('{is_resp: 1'b0, we: ld ? 4'd0 : we0, daddr: a & ~32'd3, dw: dw0,
                          rdata: 32'd0, err: 1'b0});
        if (second)
            exp_q.push_back('{is_resp: 1'b0, we: ld ? 4'd0 : we1, daddr: (a & ~32'd3) + 32'd4,
                              dw: dw1, rdata: 32'd0, err: 1'b0});
        case (f3)
            3'd0:    res = {{24{val[7]}}, val[7:0]};
            3'd1:    res = {{16{val[15]}}, val[15:0]};
            default: res = val;
        endcase
        r.err   = 1'b0;
        r.rdata = ld ? res : 32'd0;
        exp_q.push_back(r);
    endtask

    task automatic req(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] w);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_load = ld; req_funct3 = f3; req_addr = a; req_wdata = w;
        @(posedge clk);
        model(ld, f3, a, w);
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_funct3 = 3'($urandom); req_load = 1'($urandom);
        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) begin
            tests++; fails++;
            $display("FAIL timeout: trace not drained, %0d entries left, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] f3;
        logic [31:0] a;
        req_valid = 0; req_load = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        reset = 1'b0;
        for (int i = 0; i < MemBytes; i++) refmem[i] = 8'($urandom);
        #1 reset = 1'b1;
        #2;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        chk("rst_daddr", daddr, 32'd0);
        chk("rst_dwdata", dwdata, 32'd0);
        chk("rst_we", {28'd0, we}, 32'd0);
        repeat (2) @(negedge clk);
        mem_init = 1'b0;
        reset = 1'b0;

        // Reset in the middle of an ACC0 store cycle.
        hold_chk = 1'b1;
        @(negedge clk);
        req_valid = 1; req_load = 0; req_funct3 = 3'b010; req_addr = 32'h10;
        req_wdata = 32'h11223344;
        @(posedge clk);
        #1;
        chk("midrst_we_before", {28'd0, we}, 32'hF);
        chk("midrst_daddr", daddr, 32'h10);
        #1 reset = 1'b1;
        #1;
        chk("midrst_we_async", {28'd0, we}, 32'd0);
        chk("midrst_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) chk("midrst_nowrite", {24'd0, simmem[16+i]}, {24'd0, refmem[16+i]});
        hold_chk = 1'b0;

        req(0, 3'b010, 32'h20, 32'hDEADBEEF);
        chk("sw_we", {28'd0, last_we0}, 32'hF);
        chk("sw_daddr", last_daddr0, 32'h20);
        req(1, 3'b000, 32'h23, 32'h0);
        chk("lb_lit", last_rdata, 32'hFFFFFFDE);
        req(1, 3'b100, 32'h23, 32'h0);
        chk("lbu_lit", last_rdata, 32'h000000DE);
        req(1, 3'b001, 32'h22, 32'h0);
        chk("lh_lit", last_rdata, 32'hFFFFDEAD);
        req(1, 3'b101, 32'h22, 32'h0);
        chk("lhu_lit", last_rdata, 32'h0000DEAD);
        req(0, 3'b000, 32'h21, 32'h0000005A);
        chk("sb_we", {28'd0, last_we0}, 32'h2);
        chk("sb_dwdata", last_dw0, 32'h5A5A5A5A);
        req(1, 3'b010, 32'h20, 32'h0);
        chk("lw_lit", last_rdata, 32'hDEAD5AEF);
`ifdef LSU_MISALIGN_SPLIT_EN
        req(0, 3'b010, 32'h1D, 32'hAABBCCDD);
        chk("split_we0", {28'd0, last_we0}, 32'hE);
        chk("split_daddr0", last_daddr0, 32'h1C);
        chk("split_we1", {28'd0, last_we1}, 32'h1);
        chk("split_daddr1", last_daddr1, 32'h20);
        req(1, 3'b010, 32'h1D, 32'h0);
        chk("split_lw", last_rdata, 32'hAABBCCDD);
`else
        req(0, 3'b010, 32'h1D, 32'hAABBCCDD);
        chk("misalign_err", {31'd0, last_err}, 32'd1);
`endif
        req(0, 3'b011, 32'h40, 32'h12345678);
        chk("bad_f3_err", {31'd0, last_err}, 32'd1);
        req(1, 3'b010, 32'h7E, 32'h0);
        chk("oob7e_err", {31'd0, last_err}, 32'd1);
        chk("oob7e_rdata", last_rdata, 32'd0);
        req(1, 3'b010, 32'h80, 32'h0);
        chk("oob80_err", {31'd0, last_err}, 32'd1);

        for (int k = 0; k < 400; k++) begin
            case ($urandom % 6)
                0: f3 = 3'($urandom);
                1: f3 = 3'b100;
                2: f3 = 3'b101;
                3: f3 = 3'b000;
                4: f3 = 3'b001;
                default: f3 = 3'b010;
            endcase
            case ($urandom % 8)
                0: a = $urandom;
                1: a = 32'd118 + ($urandom % 12);
                default: a = $urandom % MemBytes;
            endcase
            req(1'($urandom), f3, a, $urandom);
        end

        for (int i = 0; i < MemBytes; i++) chk("mem_final", {24'd0, simmem[i]}, {24'd0, refmem[i]});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
